// File: rtl/pq_op_pkg.sv
// Shared types for the priority-queue operation sequencer.
//   op_t     : request opcodes (value 3 is reserved and reported as ILLEGAL)
//   status_t : response status codes
//   state_t  : sequencer FSM state encoding
//   op_status: decides whether an op can execute given the queue's full/empty flags
package pq_op_pkg;

    typedef enum logic [1:0] {
        ENQUEUE = 2'd0,
        DEQUEUE = 2'd1,
        REPLACE = 2'd2,
        OP_RSVD = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        SKIP_FULL  = 2'd1,
        SKIP_EMPTY = 2'd2,
        ILLEGAL    = 2'd3
    } status_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ISSUE  = 2'd1;
    localparam state_t ST_SETTLE = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    function automatic status_t op_status(input op_t op, input logic full, input logic empty);
        status_t st;
        st = OK;
        case (op)
            ENQUEUE:          st = full  ? SKIP_FULL  : OK;
            DEQUEUE, REPLACE: st = empty ? SKIP_EMPTY : OK;
            default:          st = ILLEGAL;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/pq_op_sequencer.sv
// Initiator-side front end for a RegisterTree priority queue.
// Accepts one op at a time on a valid/ready request channel, pulses the queue strobes for a
// single cycle, waits out the queue's settle gap, and returns the popped value (dequeue/replace)
// or the new root (enqueue) with a status on a valid/ready response channel.
//
// Ports:
//   i_CLK, i_RSTn                  clock, asynchronous active-low reset
//   i_req_valid/o_req_ready        request handshake
//   i_req_op, i_req_data           opcode (op_t) and key
//   o_pq_wrt, o_pq_read, o_pq_data queue strobes (registered, single cycle) and write data
//   i_pq_full, i_pq_empty          queue status flags
//   i_pq_data                      queue root
//   o_rsp_valid/i_rsp_ready        response handshake
//   o_rsp_data, o_rsp_status       response value and status (status_t)
//   o_count                        shadow occupancy, saturating at 0..QUEUE_SIZE
module pq_op_sequencer
    import pq_op_pkg::*;
#(
    parameter int unsigned QUEUE_SIZE = 15,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ENQ_GAP    = $clog2(QUEUE_SIZE) + 3,
    parameter int unsigned DEQ_GAP    = 3
) (
    input  logic                              i_CLK,
    input  logic                              i_RSTn,
    input  logic                              i_req_valid,
    output logic                              o_req_ready,
    input  logic [1:0]                        i_req_op,
    input  logic [DATA_WIDTH-1:0]             i_req_data,
    output logic                              o_pq_wrt,
    output logic                              o_pq_read,
    output logic [DATA_WIDTH-1:0]             o_pq_data,
    input  logic                              i_pq_full,
    input  logic                              i_pq_empty,
    input  logic [DATA_WIDTH-1:0]             i_pq_data,
    output logic                              o_rsp_valid,
    input  logic                              i_rsp_ready,
    output logic [DATA_WIDTH-1:0]             o_rsp_data,
    output logic [1:0]                        o_rsp_status,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count
);

    localparam int unsigned CntW   = $clog2(QUEUE_SIZE + 1);
    localparam int unsigned MaxGap = (ENQ_GAP > DEQ_GAP) ? ENQ_GAP : DEQ_GAP;
    localparam int unsigned GapW   = $clog2(MaxGap + 1);

    localparam logic [CntW-1:0] CntMax  = CntW'(QUEUE_SIZE);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [GapW-1:0] GapOne  = GapW'(1);
    localparam logic [GapW-1:0] EnqLoad = GapW'(ENQ_GAP - 1);
    localparam logic [GapW-1:0] DeqLoad = GapW'(DEQ_GAP - 1);

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    status_t               status_q, status_d;
    status_t               acc_status;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic                  wrt_q, wrt_d;
    logic                  read_q, read_d;
    logic                  req_ready_q, req_ready_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        status_d   = status_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        count_d    = count_q;
        gap_d      = gap_q;
        wrt_d      = 1'b0;
        read_d     = 1'b0;
        acc_status = OK;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    op_d       = op_t'(i_req_op);
                    data_d     = i_req_data;
                    rsp_data_d = '0;
                    // Legality is resolved at acceptance so the strobes can be registered and
                    // land exactly in the ISSUE cycle.
                    acc_status = op_status(op_d, i_pq_full, i_pq_empty);
                    status_d   = acc_status;
                    if (acc_status == OK) begin
                        wrt_d  = (op_d == ENQUEUE) || (op_d == REPLACE);
                        read_d = (op_d == DEQUEUE) || (op_d == REPLACE);
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (status_q == OK) begin
                    state_d = ST_SETTLE;
                    gap_d   = (op_q == ENQUEUE) ? EnqLoad : DeqLoad;
                    case (op_q)
                        ENQUEUE: begin
                            if (count_q < CntMax) count_d = count_q + CntOne;
                        end
                        DEQUEUE: begin
                            rsp_data_d = i_pq_data;
                            if (count_q != '0) count_d = count_q - CntOne;
                        end
                        REPLACE: begin
                            rsp_data_d = i_pq_data;
                        end
                        default: ;
                    endcase
                end else begin
                    state_d = ST_RESP;
                end
            end

            ST_SETTLE: begin
                if (gap_q == '0) begin
                    state_d = ST_RESP;
                    // After an enqueue the response carries the settled root.
                    if (op_q == ENQUEUE) rsp_data_d = i_pq_data;
                end else begin
                    gap_d = gap_q - GapOne;
                end
            end

            ST_RESP: begin
                if (i_rsp_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // Registered so that ready reads 0 while reset is held.
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q     <= ST_IDLE;
            op_q        <= ENQUEUE;
            status_q    <= OK;
            data_q      <= '0;
            rsp_data_q  <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            wrt_q       <= 1'b0;
            read_q      <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            status_q    <= status_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            wrt_q       <= wrt_d;
            read_q      <= read_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign o_req_ready  = req_ready_q;
    assign o_pq_wrt     = wrt_q;
    assign o_pq_read    = read_q;
    assign o_pq_data    = data_q;
    assign o_rsp_valid  = (state_q == ST_RESP);
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_status = status_q;
    assign o_count      = count_q;

endmodule

// File: tb/tb_pq_op_sequencer.sv
// Bench for pq_op_sequencer: a max-first priority queue environment, a per-cycle reference
// model of the sequencer's externally visible behaviour, directed scenarios and random traffic.
module tb_pq_op_sequencer;

    localparam int QS = 15;
    localparam int DW = 16;
    localparam int EG = 7;
    localparam int DG = 3;
    localparam int CW = 4;

    localparam logic [1:0] O_ENQ = 2'd0;
    localparam logic [1:0] O_DEQ = 2'd1;
    localparam logic [1:0] O_REP = 2'd2;
    localparam logic [1:0] O_ILL = 2'd3;

    localparam logic [1:0] S_OK    = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_EMPTY = 2'd2;
    localparam logic [1:0] S_ILL   = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [DW-1:0] req_data = '0;
    logic          pq_wrt, pq_read;
    logic [DW-1:0] pq_wdata;
    logic          pq_full = 1'b0;
    logic          pq_empty = 1'b1;
    logic [DW-1:0] pq_root = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;

    pq_op_sequencer #(
        .QUEUE_SIZE(QS),
        .DATA_WIDTH(DW),
        .ENQ_GAP   (EG),
        .DEQ_GAP   (DG)
    ) dut (
        .i_CLK       (clk),
        .i_RSTn      (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_data  (req_data),
        .o_pq_wrt    (pq_wrt),
        .o_pq_read   (pq_read),
        .o_pq_data   (pq_wdata),
        .i_pq_full   (pq_full),
        .i_pq_empty  (pq_empty),
        .i_pq_data   (pq_root),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_status(rsp_status),
        .o_count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qmax_idx(input logic [DW-1:0] q[$]);
        int idx;
        idx = 0;
        for (int i = 1; i < q.size(); i++) if (q[i] > q[idx]) idx = i;
        return idx;
    endfunction

    // Queue environment: max key at the root, updates on the edge that samples a strobe.
    logic [DW-1:0] env_q[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_q.delete();
            pq_full  <= 1'b0;
            pq_empty <= 1'b1;
            pq_root  <= '0;
        end else begin
            if (pq_read && env_q.size() > 0) env_q.delete(qmax_idx(env_q));
            if (pq_wrt && env_q.size() < QS) env_q.push_back(pq_wdata);
            pq_full  <= (env_q.size() == QS);
            pq_empty <= (env_q.size() == 0);
            pq_root  <= (env_q.size() > 0) ? env_q[qmax_idx(env_q)] : '0;
        end
    end

    // Reference model: one op in flight; timing derived from accept cycle and gap length.
    logic [DW-1:0] ref_q[$];
    int            k = 0;
    int            rcnt = 0;
    bit            busy = 0;
    int            acc = 0;
    int            rsp_start = 0;
    int            m_count = 0;
    int            m_count_next = 0;
    logic [1:0]    m_op, m_st;
    logic [DW-1:0] m_data, m_rsp;

    always @(negedge clk) begin
        k++;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_strobes", {pq_wrt, pq_read}, 0);
            chk("rst_pq_data", pq_wdata, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_status", rsp_status, 0);
            chk("rst_count", count, 0);
            busy = 0;
            ref_q.delete();
            m_count = 0;
            rcnt = 0;
        end else begin
            rcnt++;
            if (!busy) begin
                chk("idle_strobes", {pq_wrt, pq_read}, 0);
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_count", count, m_count);
                if (rcnt >= 2) chk("idle_req_ready", req_ready, 1);
                if (req_valid && req_ready) begin
                    int gap;
                    m_op = req_op;
                    m_data = req_data;
                    m_rsp = '0;
                    m_count_next = m_count;
                    gap = DG;
                    case (m_op)
                        O_ENQ: begin
                            if (ref_q.size() == QS) m_st = S_FULL;
                            else begin
                                m_st = S_OK;
                                ref_q.push_back(m_data);
                                m_rsp = ref_q[qmax_idx(ref_q)];
                                m_count_next = m_count + 1;
                                gap = EG;
                            end
                        end
                        O_DEQ, O_REP: begin
                            if (ref_q.size() == 0) m_st = S_EMPTY;
                            else begin
                                int mi;
                                m_st = S_OK;
                                mi = qmax_idx(ref_q);
                                m_rsp = ref_q[mi];
                                ref_q.delete(mi);
                                if (m_op == O_REP) ref_q.push_back(m_data);
                                else m_count_next = m_count - 1;
                            end
                        end
                        default: m_st = S_ILL;
                    endcase
                    busy = 1;
                    acc = k;
                    rsp_start = (m_st == S_OK) ? acc + 2 + gap : acc + 2;
                end
            end else begin
                chk("busy_req_ready", req_ready, 0);
                chk("busy_count", count, m_count);
                if (k == acc + 1) begin
                    chk("issue_wrt", pq_wrt, (m_st == S_OK) && (m_op == O_ENQ || m_op == O_REP));
                    chk("issue_read", pq_read, (m_st == S_OK) && (m_op == O_DEQ || m_op == O_REP));
                    if (m_st == S_OK && m_op != O_DEQ) chk("issue_pq_data", pq_wdata, m_data);
                    m_count = m_count_next;
                end else begin
                    chk("quiet_strobes", {pq_wrt, pq_read}, 0);
                end
                chk("rsp_valid_timing", rsp_valid, k >= rsp_start);
                if (k >= rsp_start) begin
                    chk("rsp_data", rsp_data, m_rsp);
                    chk("rsp_status", rsp_status, m_st);
                    if (rsp_ready) busy = 0;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_op(input logic [1:0] op, input logic [DW-1:0] d, input int hold,
                         output logic [DW-1:0] rd, output logic [1:0] rs, output int lat);
        bit got;
        int n;
        rd = '0;
        rs = 2'd0;
        lat = -1;
        req_op = op;
        req_data = d;
        req_valid = 1'b1;
        got = 0;
        n = 0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (req_ready) got = 1;
        end
        if (!got) begin
            chk("req_accept_timeout", 0, 1);
            @(posedge clk);
            #1 req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0;
        n = 0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1;
        end
        if (!got) begin
            chk("rsp_timeout", 0, 1);
            @(posedge clk);
            #1;
            return;
        end
        lat = n;
        rd = rsp_data;
        rs = rsp_status;
        repeat (hold + 1) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    logic [DW-1:0] rd;
    logic [1:0]    rs;
    int            lat;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset_ready_low", req_ready, 0);
        chk("reset_count_zero", count, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // First enqueue: new root is the key itself, 9-cycle latency.
        do_op(O_ENQ, 16'd700, 0, rd, rs, lat);
        chk("enq700_status", rs, S_OK);
        chk("enq700_data", rd, 700);
        chk("enq700_latency", lat, 9);
        chk("enq700_count", count, 1);
        do_op(O_DEQ, 16'd0, 0, rd, rs, lat);
        chk("deq700_data", rd, 700);
        chk("deq700_latency", lat, 5);

        do_op(O_ENQ, 16'd5, 0, rd, rs, lat);
        do_op(O_ENQ, 16'd900, 1, rd, rs, lat);
        chk("enq900_root", rd, 900);
        do_op(O_ENQ, 16'd300, 0, rd, rs, lat);
        chk("enq300_root", rd, 900);
        do_op(O_DEQ, 16'd0, 0, rd, rs, lat);
        chk("pop1", rd, 900);
        do_op(O_DEQ, 16'd0, 2, rd, rs, lat);
        chk("pop2", rd, 300);
        do_op(O_DEQ, 16'd0, 0, rd, rs, lat);
        chk("pop3", rd, 5);
        chk("pop3_status", rs, S_OK);
        chk("drained_count", count, 0);

        // Empty / full boundaries.
        do_op(O_DEQ, 16'd0, 0, rd, rs, lat);
        chk("deq_empty_status", rs, S_EMPTY);
        chk("deq_empty_data", rd, 0);
        chk("deq_empty_latency", lat, 2);
        do_op(O_REP, 16'd9, 0, rd, rs, lat);
        chk("rep_empty_status", rs, S_EMPTY);
        for (int i = 0; i < QS; i++) do_op(O_ENQ, DW'(i * 37 + 11), 0, rd, rs, lat);
        chk("fill_count", count, 15);
        do_op(O_ENQ, 16'd1234, 0, rd, rs, lat);
        chk("enq_full_status", rs, S_FULL);
        chk("enq_full_data", rd, 0);
        chk("enq_full_latency", lat, 2);
        chk("enq_full_count", count, 15);
        do_op(O_DEQ, 16'd0, 0, rd, rs, lat);
        chk("full_pop_max", rd, 14 * 37 + 11);
        for (int i = 1; i < QS; i++) do_op(O_DEQ, 16'd0, 0, rd, rs, lat);
        chk("empty_again_count", count, 0);

        // Replace on {800, 200}.
        do_op(O_ENQ, 16'd800, 0, rd, rs, lat);
        do_op(O_ENQ, 16'd200, 0, rd, rs, lat);
        do_op(O_REP, 16'd1000, 0, rd, rs, lat);
        chk("rep_status", rs, S_OK);
        chk("rep_data", rd, 800);
        chk("rep_latency", lat, 5);
        chk("rep_count", count, 2);
        do_op(O_DEQ, 16'd0, 0, rd, rs, lat);
        chk("rep_next_root", rd, 1000);
        do_op(O_DEQ, 16'd0, 0, rd, rs, lat);
        chk("rep_last", rd, 200);

        // Long response backpressure, then an illegal opcode.
        do_op(O_ENQ, 16'd77, 10, rd, rs, lat);
        chk("hold_data", rd, 77);
        chk("hold_rsp_gone", rsp_valid, 0);
        do_op(O_ILL, 16'd5, 0, rd, rs, lat);
        chk("illegal_status", rs, S_ILL);
        chk("illegal_data", rd, 0);
        chk("illegal_latency", lat, 2);

        // Reset in the middle of an enqueue's settle gap.
        req_op = O_ENQ;
        req_data = 16'd55;
        req_valid = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!req_ready && n < 64);
            chk("mid_rst_accept", req_ready, 1);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_strobes", {pq_wrt, pq_read}, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        chk("mid_rst_count", count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_op(O_ENQ, 16'd42, 0, rd, rs, lat);
        chk("post_rst_status", rs, S_OK);
        chk("post_rst_data", rd, 42);
        chk("post_rst_count", count, 1);

        // Random traffic alternating between filling and draining phases.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] op;
            r = $urandom_range(99);
            if (r < 5) op = O_ILL;
            else if (((i / 50) % 2) == 0) op = (r < 70) ? O_ENQ : (r < 85) ? O_DEQ : O_REP;
            else op = (r < 25) ? O_ENQ : (r < 80) ? O_DEQ : O_REP;
            do_op(op, DW'($urandom_range(65535)), $urandom_range(3), rd, rs, lat);
        end
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
